// File: rtl/uart_prog_loader.sv
// UART-fed program loader: filters Brainfuck opcodes out of an 8N1 byte stream,
// tracks bracket depth and writes opcodes plus a 0x00 terminator into program memory.
module uart_prog_loader #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx,
    input  logic                  load_req,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] prog_len,
    output logic [1:0]            err
);
    // state    | meaning
    // RX_IDLE  | waiting for a falling edge on the synchronized line
    // RX_START | timing to mid start bit, rejecting glitches
    // RX_DATA  | sampling 8 data bits, LSB first
    // RX_STOP  | sampling the stop bit, byte completes here
    // L_IDLE   | not armed, received bytes are dropped
    // L_LOAD   | filtering and writing opcodes
    // L_FINISH | EOT seen: bracket check, terminator write
    // L_ERR    | error recorded, dropping busy
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_FINISH, L_ERR} ld_state_t;

    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t       r_rx_state, w_rx_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            w_byte_vld, w_byte_ferr, w_is_op;

    ld_state_t             r_ld_state, w_ld_state_n;
    logic                  r_wr_en, w_wr_en_n;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic                  r_inc_pend, w_inc_pend_n;
    logic [7:0]            r_wr_data, w_wr_data_n;
    logic [ADDR_WIDTH-1:0] r_depth, w_depth_n;
    logic                  r_busy, w_busy_n;
    logic                  r_done, w_done_n;
    logic [ADDR_WIDTH-1:0] r_prog_len, w_prog_len_n;
    logic [1:0]            r_err, w_err_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_shift    <= w_shift_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_cnt_n      = r_cnt;
        w_bit_n      = r_bit;
        w_shift_n    = r_shift;
        w_byte_vld   = 1'b0;
        w_byte_ferr  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_n = RX_START;
                    w_cnt_n      = HALF_LAST;
                end
            end
            RX_START: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
                end else if (r_rx_sync) begin
                    w_rx_state_n = RX_IDLE;
                end else begin
                    w_rx_state_n = RX_DATA;
                    w_cnt_n      = BIT_LAST;
                    w_bit_n      = '0;
                end
            end
            RX_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
                end else begin
                    w_shift_n = {r_rx_sync, r_shift[7:1]};
                    w_cnt_n   = BIT_LAST;
                    if (r_bit == 3'd7) w_rx_state_n = RX_STOP;
                    else               w_bit_n = r_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
                end else begin
                    w_rx_state_n = RX_IDLE;
                    w_byte_vld   = 1'b1;
                    w_byte_ferr  = !r_rx_sync;
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    assign w_is_op = r_shift inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ld_state <= L_IDLE;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_inc_pend <= 1'b0;
            r_wr_data  <= '0;
            r_depth    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_prog_len <= '0;
            r_err      <= '0;
        end else begin
            r_ld_state <= w_ld_state_n;
            r_wr_en    <= w_wr_en_n;
            r_addr     <= w_addr_n;
            r_inc_pend <= w_inc_pend_n;
            r_wr_data  <= w_wr_data_n;
            r_depth    <= w_depth_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_prog_len <= w_prog_len_n;
            r_err      <= w_err_n;
        end
    end

    // The address advances one cycle after each opcode write so wr_addr is stable
    // while wr_en is high; busy stays up through the done cycle and drops after it.
    always_comb begin
        w_ld_state_n = r_ld_state;
        w_wr_en_n    = 1'b0;
        w_addr_n     = r_inc_pend ? r_addr + 1'b1 : r_addr;
        w_inc_pend_n = 1'b0;
        w_wr_data_n  = r_wr_data;
        w_depth_n    = r_depth;
        w_busy_n     = r_done ? 1'b0 : r_busy;
        w_done_n     = 1'b0;
        w_prog_len_n = r_prog_len;
        w_err_n      = r_err;
        case (r_ld_state)
            L_IDLE: begin
                if (load_req) begin
                    w_err_n      = 2'd0;
                    w_depth_n    = '0;
                    w_addr_n     = '0;
                    w_busy_n     = 1'b1;
                    w_ld_state_n = L_LOAD;
                end
            end
            L_LOAD: begin
                if (w_byte_vld) begin
                    if (w_byte_ferr) begin
                        w_err_n      = 2'd3;
                        w_ld_state_n = L_ERR;
                    end else if (r_shift == 8'h04) begin
                        w_ld_state_n = L_FINISH;
                    end else if (w_is_op) begin
                        if (r_addr == ADDR_LAST) begin
                            w_err_n      = 2'd2;
                            w_ld_state_n = L_ERR;
                        end else if (r_shift == 8'h5D && r_depth == '0) begin
                            w_err_n      = 2'd1;
                            w_ld_state_n = L_ERR;
                        end else begin
                            w_wr_en_n    = 1'b1;
                            w_wr_data_n  = r_shift;
                            w_inc_pend_n = 1'b1;
                            if (r_shift == 8'h5B)      w_depth_n = r_depth + 1'b1;
                            else if (r_shift == 8'h5D) w_depth_n = r_depth - 1'b1;
                        end
                    end
                end
            end
            L_FINISH: begin
                if (r_depth != '0) begin
                    w_err_n      = 2'd1;
                    w_ld_state_n = L_ERR;
                end else begin
                    w_wr_en_n    = 1'b1;
                    w_wr_data_n  = 8'h00;
                    w_prog_len_n = r_addr;
                    w_done_n     = 1'b1;
                    w_ld_state_n = L_IDLE;
                end
            end
            L_ERR: begin
                w_busy_n     = 1'b0;
                w_ld_state_n = L_IDLE;
            end
            default: w_ld_state_n = L_IDLE;
        endcase
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign prog_len = r_prog_len;
    assign err      = r_err;
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Receives a Brainfuck program as a byte stream over UART, discards every byte that is not one of the eight opcodes, checks bracket balance, and writes the filtered opcodes sequentially into the CPU's program memory. It sits upstream of `cpu_core`: it is armed by the debounced "load program" pulse and drives the program-memory write port. It reports completion through `done`/`prog_len`, which feed the core's `loaded` indication.

## Interface
- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `BAUD`, 115200, UART bit rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division, must be ≥ 4).
- `ADDR_WIDTH`, 12, program memory address width; `DEPTH = 2**ADDR_WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, idle high, 8N1, LSB first; asynchronous to `clk`.
- `load_req`  in  1  single-cycle pulse that arms a load.
- `wr_en`  out  1  program-memory write strobe, one cycle per byte.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `wr_data`  out  8  opcode byte to write.
- `busy`  out  1  high from arm until `done` or `err`.
- `done`  out  1  one-cycle pulse on successful completion.
- `prog_len`  out  ADDR_WIDTH  opcode count of the last successful load; held until the next successful load.
- `err`  out  2  sticky error code: 0 none, 1 bracket imbalance, 2 overflow, 3 framing. Cleared on the next arm.

## Operation
- `rx` passes through a 2-FF synchronizer before any use.
- UART receiver states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - A falling edge in RX_IDLE enters RX_START.
  - At `CLKS_PER_BIT/2` the line is sampled. If it is high, the start bit is a glitch: return to RX_IDLE and emit no byte.
  - Data bits are then sampled every `CLKS_PER_BIT`, LSB first.
  - Stop-bit sample = 0 is a framing error.
  - The receiver runs whenever the block is not in reset, even when not armed. Bytes received while not armed are discarded.
- Loader states: L_IDLE, L_LOAD, L_FINISH, L_ERR.
  - L_IDLE: `load_req` clears `err`, depth and address, sets `busy`, and goes to L_LOAD.
  - L_LOAD, per received byte:
    - Opcode (`+ - < > [ ] . ,`, i.e. 0x2B 0x2D 0x3C 0x3E 0x5B 0x5D 0x2E 0x2C): write it at `wr_addr`, then increment `wr_addr`.
    - `[`: depth+1.
    - `]`: depth−1. If depth is already 0, set err=1 and go to L_ERR without writing.
    - 0x04 (EOT): go to L_FINISH.
    - Framing error: err=3, go to L_ERR.
    - Any other byte: ignored.
  - Bracket depth counter is ADDR_WIDTH bits wide and cannot overflow, because depth ≤ address.
  - Overflow: an opcode arriving when `wr_addr == DEPTH-1` is not written; set err=2 and go to L_ERR. Slot `DEPTH-1` is always reserved for the terminator.
  - L_FINISH:
    - If depth ≠ 0: err=1, go to L_ERR.
    - Otherwise write 0x00 at `wr_addr`, set `prog_len = wr_addr`, pulse `done`, clear `busy`, and go to L_IDLE.
  - L_ERR: clear `busy`, go to L_IDLE. `prog_len` is unchanged. Memory contents are undefined.
- `load_req` during L_LOAD/L_FINISH is ignored.
- A byte completing in the same cycle as `load_req` in L_IDLE is discarded.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `prog_len`=0, `err`=0, receiver in RX_IDLE, loader in L_IDLE.
- Reset asserted mid-load aborts immediately; memory already written is not restored.
- `busy` rises the cycle after `load_req`.
- Opcode write latency:
  - `wr_en` is asserted exactly 1 cycle after the stop-bit sample cycle.
  - `wr_addr`/`wr_data` are valid in that same cycle.
  - `wr_addr` increments the following cycle.
- EOT: the terminator write cycle and the `done` pulse occur in the same cycle, 2 cycles after the EOT stop-bit sample. `prog_len` is valid in that cycle; `busy` is low from the next cycle.
- Stop-bit sample occurs (9.5 × CLKS_PER_BIT) ± 1 cycles after the synchronized falling edge, plus 2 cycles of synchronizer delay.
- `wr_en` is never high on two consecutive cycles.

## Test plan
- Arm, send "+[->+<]." then 0x04 → 8 writes at addresses 0..7 with the matching bytes, then 0x00 at address 8; `done` pulse; `prog_len`=8; `err`=0.
- Arm, send "a+\n b-" then EOT → writes 0x2B@0, 0x2D@1, 0x00@2; `prog_len`=2.
- Arm, send "]" → no write; `err`=1; `busy` low; `prog_len` keeps its previous value. Then arm and send "[[]" + EOT → `err`=1 and no `done`.
- ADDR_WIDTH=3: arm, send 8 '+' → writes at addresses 0..6; 8th byte not written; `err`=2.
- Arm, send byte 0x2B with stop bit driven low → no write; `err`=3. Then re-arm → `err` returns to 0.
- Assert `resetn` low mid-byte during L_LOAD → all outputs return to reset values. A 1/4-bit low glitch on `rx` → no byte received.
